// File: rtl/experiment_stand_emulator_if.sv
// Stand-side signal bundle between the sync FSM and the stand emulator.
// fault_mode exists only when EMU_FAULT_INJECT_EN is defined.
interface experiment_stand_emulator_if;
  logic       arm;
  logic       detonator_triggered;
  logic       output_trigger;
`ifdef EMU_FAULT_INJECT_EN
  logic [1:0] fault_mode;
`endif
  logic       phase;
  logic       start;
  logic       fg_opto;
  logic       wire_sensor;
  logic       detector_ready;
  logic       done;
  logic       seq_error;

`ifdef EMU_FAULT_INJECT_EN
  modport master (
    output arm, detonator_triggered, output_trigger, fault_mode,
    input  phase, start, fg_opto, wire_sensor,
    input  detector_ready, done, seq_error
  );
  modport slave (
    input  arm, detonator_triggered, output_trigger, fault_mode,
    output phase, start, fg_opto, wire_sensor,
    output detector_ready, done, seq_error
  );
`else
  modport master (
    output arm, detonator_triggered, output_trigger,
    input  phase, start, fg_opto, wire_sensor,
    input  detector_ready, done, seq_error
  );
  modport slave (
    input  arm, detonator_triggered, output_trigger,
    output phase, start, fg_opto, wire_sensor,
    output detector_ready, done, seq_error
  );
`endif
endinterface

// File: rtl/experiment_stand_emulator.sv
// Experiment stand emulator: phase/start/fg_opto stimuli and delayed replies.
// Optional fault injection enabled by defining EMU_FAULT_INJECT_EN.
module experiment_stand_emulator #(
  parameter int unsigned PHASE_HALF_PERIOD = 120,
  parameter int unsigned START_LEN         = 4,
  parameter int unsigned FG_OPTO_DELAY     = 1000,
  parameter int unsigned WIRE_DELAY        = 40,
  parameter int unsigned READY_DELAY       = 200
) (
  input logic clock,
  input logic reset,
  experiment_stand_emulator_if.slave bus
);

  localparam logic [31:0] HP =
    (PHASE_HALF_PERIOD == 0) ? 32'd1 : 32'(PHASE_HALF_PERIOD);
  localparam logic [31:0] SL =
    (START_LEN == 0) ? 32'd1 : 32'(START_LEN);
  localparam logic [31:0] FD =
    (FG_OPTO_DELAY == 0) ? 32'd1 : 32'(FG_OPTO_DELAY);
  localparam logic [31:0] WD =
    (WIRE_DELAY == 0) ? 32'd1 : 32'(WIRE_DELAY);
  localparam logic [31:0] RD =
    (READY_DELAY == 0) ? 32'd1 : 32'(READY_DELAY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_FG,
    S_WAIT_DET,
    S_WIRE,
    S_WAIT_TRIG,
    S_READY,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [31:0] ph_cnt_q;
  logic        phase_q;
  logic        det_q;
  logic        trig_q;
  logic        start_q;
  logic        fg_q;
  logic        wire_q;
  logic        rdy_q;
  logic        done_q;
  logic        err_q;
  logic [1:0]  fault_q;
  logic [1:0]  fault_d;
  logic        det_edge;
  logic        trig_edge;
  logic        no_fg;
  logic        no_wire;
  logic        no_ready;

`ifdef EMU_FAULT_INJECT_EN
  assign fault_d = bus.fault_mode;
`else
  assign fault_d = 2'd0;
`endif

  assign no_wire  = (fault_q == 2'd1);
  assign no_ready = (fault_q == 2'd2);
  assign no_fg    = (fault_q == 2'd3);

  assign det_edge  = bus.detonator_triggered & ~det_q;
  assign trig_edge = bus.output_trigger & ~trig_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ph_cnt_q <= '0;
      phase_q  <= 1'b0;
    end else if (ph_cnt_q == HP - 32'd1) begin
      ph_cnt_q <= '0;
      phase_q  <= ~phase_q;
    end else begin
      ph_cnt_q <= ph_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      det_q  <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      det_q  <= bus.detonator_triggered;
      trig_q <= bus.output_trigger;
    end
  end

  // Each delay of D cycles is timed from the edge cycle, so the wait
  // state itself lasts D-1 cycles and is skipped entirely when D is 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      fg_q    <= 1'b0;
      wire_q  <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= 2'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.arm) begin
            state_q <= S_START;
            start_q <= 1'b1;
            cnt_q   <= SL - 32'd1;
            fault_q <= fault_d;
          end
        end
        S_START: begin
          if (cnt_q == 32'd0) begin
            start_q <= 1'b0;
            if (FD == 32'd1) begin
              fg_q    <= ~no_fg;
              state_q <= S_WAIT_DET;
            end else begin
              cnt_q   <= FD - 32'd2;
              state_q <= S_WAIT_FG;
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_WAIT_FG: begin
          if (det_edge || trig_edge) err_q <= 1'b1;
          if (cnt_q == 32'd0) begin
            fg_q    <= ~no_fg;
            state_q <= S_WAIT_DET;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_WAIT_DET: begin
          if (trig_edge) err_q <= 1'b1;
          if (det_edge) begin
            if (WD == 32'd1) begin
              wire_q  <= ~no_wire;
              state_q <= S_WAIT_TRIG;
            end else begin
              cnt_q   <= WD - 32'd2;
              state_q <= S_WIRE;
            end
          end
        end
        S_WIRE: begin
          if (trig_edge) err_q <= 1'b1;
          if (cnt_q == 32'd0) begin
            wire_q  <= ~no_wire;
            state_q <= S_WAIT_TRIG;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_WAIT_TRIG: begin
          if (trig_edge) begin
            if (RD == 32'd1) begin
              rdy_q   <= ~no_ready;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cnt_q   <= RD - 32'd2;
              state_q <= S_READY;
            end
          end
        end
        S_READY: begin
          if (cnt_q == 32'd0) begin
            rdy_q   <= ~no_ready;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_DONE: begin
          if (bus.arm) begin
            state_q <= S_START;
            start_q <= 1'b1;
            cnt_q   <= SL - 32'd1;
            fault_q <= fault_d;
            fg_q    <= 1'b0;
            wire_q  <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.phase          = phase_q;
  assign bus.start          = start_q;
  assign bus.fg_opto        = fg_q;
  assign bus.wire_sensor    = wire_q;
  assign bus.detector_ready = rdy_q;
  assign bus.done           = done_q;
  assign bus.seq_error      = err_q;

endmodule

// File: tb/tb_experiment_stand_emulator.sv
// Bench for experiment_stand_emulator: timeline-based reference model.
// Fault scenario is compiled only when EMU_FAULT_INJECT_EN is defined.
module tb_experiment_stand_emulator;

  localparam int H  = 120;
  localparam int SL = 4;
  localparam int FD = 1000;
  localparam int WD = 40;
  localparam int RD = 200;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  experiment_stand_emulator_if bus();

  experiment_stand_emulator #(
    .PHASE_HALF_PERIOD(H),
    .START_LEN(SL),
    .FG_OPTO_DELAY(FD),
    .WIRE_DELAY(WD),
    .READY_DELAY(RD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // Model: absolute event times of the current shot
  longint t;
  bit     armed;
  longint n, m, k;
  bit     m_v, k_v;
  bit     err_e;
  int     fm;
  int     fault_sel;
  bit     pdet, ptrig;

  int passed = 0;
  int total  = 0;

  function automatic logic [6:0] expv();
    logic ph, s, f, w, r;
    ph = ((t / H) % 2) == 1;
    s  = armed && (t >= n + 1) && (t <= n + SL);
    f  = armed && (t >= n + SL + FD) && (fm != 3);
    w  = m_v && (t >= m + WD) && (fm != 1);
    r  = k_v && (t >= k + RD);
    return {ph, s, f, w, r && (fm != 2), r, err_e};
  endfunction

  function automatic logic [6:0] obsv();
    return {bus.phase, bus.start, bus.fg_opto, bus.wire_sensor,
            bus.detector_ready, bus.done, bus.seq_error};
  endfunction

  task automatic model_reset();
    t = 0; armed = 0; m_v = 0; k_v = 0;
    err_e = 0; fm = 0; pdet = 0; ptrig = 0;
  endtask

  // Apply inputs seen in cycle t to the shot timeline
  task automatic model_step(input bit a, input bit d, input bit g);
    bit de, te, pre_wire;
    longint fg_t;
    de = d && !pdet;
    te = g && !ptrig;
    if (armed) begin
      fg_t = n + SL + FD;
      pre_wire = (t >= n + SL + 1) && !(m_v && t >= m + WD);
      if (te && pre_wire) err_e = 1;
      else if (te && m_v && t >= m + WD && !k_v) begin
        k = t; k_v = 1;
      end
      if (de && t >= n + SL + 1 && t < fg_t) err_e = 1;
      else if (de && t >= fg_t && !m_v) begin
        m = t; m_v = 1;
      end
    end
    if (a && (!armed || (k_v && t >= k + RD))) begin
      armed = 1; n = t; m_v = 0; k_v = 0;
      err_e = 0; fm = fault_sel;
    end
    pdet = d;
    ptrig = g;
  endtask

  task automatic drive(input bit a, input bit d, input bit g);
    bus.arm = a;
    bus.detonator_triggered = d;
    bus.output_trigger = g;
    model_step(a, d, g);
    @(posedge clock);
    #1;
    t++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [6:0] o;
    o = obsv();
    total++;
    if (o !== 7'b0)
      $display("FAIL reset_state t=%0d got=%b exp=%b", t, o, 7'b0);
    else passed++;
  endtask

  task automatic test_phase();
    logic [6:0] o, e;
    while (t < 1000) begin
      o = obsv(); e = expv();
      total++;
      if (o !== e)
        $display("FAIL phase_idle t=%0d got=%b exp=%b", t, o, e);
      else passed++;
      drive(0, 0, 0);
    end
  endtask

  task automatic test_full_shot();
    logic [6:0] o, e;
    longint b;
    int dw, gw;
    b  = t + $urandom_range(1, 30);
    dw = $urandom_range(1, 60);
    gw = $urandom_range(1, 60);
    while (t < b + 1450) begin
      o = obsv(); e = expv();
      total++;
      if (o !== e)
        $display("FAIL full_shot t=%0d rel=%0d got=%b exp=%b", t, t - b, o, e);
      else passed++;
      drive(t == b,
            t >= b + 1100 && t < b + 1100 + dw,
            t >= b + 1200 && t < b + 1200 + gw);
    end
  endtask

  task automatic test_rearm();
    logic [6:0] o, e;
    longint b, md, kt;
    b  = t + $urandom_range(1, 40);
    md = b + SL + FD + $urandom_range(0, 60);
    kt = md + WD + $urandom_range(0, 60);
    while (t < kt + RD + 20) begin
      o = obsv(); e = expv();
      total++;
      if (o !== e)
        $display("FAIL rearm t=%0d rel=%0d got=%b exp=%b", t, t - b, o, e);
      else passed++;
      drive(t >= b && t < b + 3,
            t >= md && t < md + 5,
            t >= kt && t < kt + 5);
    end
  endtask

  task automatic test_out_of_order();
    logic [6:0] o, e;
    longint b, bad, md, kt;
    b   = t + $urandom_range(1, 20);
    bad = b + SL + FD + $urandom_range(2, 40);
    md  = bad + $urandom_range(10, 40);
    kt  = md + WD + $urandom_range(1, 30);
    while (t < kt + RD + 20) begin
      o = obsv(); e = expv();
      total++;
      if (o !== e)
        $display("FAIL out_of_order t=%0d rel=%0d got=%b exp=%b", t, t - b, o, e);
      else passed++;
      drive(t == b,
            t >= md && t < md + 4,
            (t >= bad && t < bad + 3) || (t >= kt && t < kt + 3));
    end
  endtask

  task automatic test_reset_mid_shot();
    logic [6:0] o, e;
    longint b, md;
    b  = t + $urandom_range(1, 20);
    md = b + SL + FD + $urandom_range(0, 30);
    while (t < md + 20) begin
      o = obsv(); e = expv();
      total++;
      if (o !== e)
        $display("FAIL pre_reset t=%0d got=%b exp=%b", t, o, e);
      else passed++;
      drive(t == b, t >= md, 0);
    end
    do_reset();
    while (t < 1300) begin
      o = obsv(); e = expv();
      total++;
      if (o !== e)
        $display("FAIL post_reset t=%0d got=%b exp=%b", t, o, e);
      else passed++;
      drive(0, t < 10 || (t >= 50 && t < 60), t >= 200 && t < 210);
    end
  endtask

  task automatic test_random();
    logic [6:0] o, e;
    bit d, g;
    longint stop;
    d = 0; g = 0;
    stop = t + 8000;
    while (t < stop) begin
      o = obsv(); e = expv();
      total++;
      if (o !== e)
        $display("FAIL random t=%0d got=%b exp=%b", t, o, e);
      else passed++;
      if ($urandom_range(0, 299) == 0) d = ~d;
      if ($urandom_range(0, 299) == 0) g = ~g;
      drive($urandom_range(0, 199) == 0, d, g);
    end
    while (d || g) begin
      d = 0; g = 0;
      drive(0, 0, 0);
    end
  endtask

`ifdef EMU_FAULT_INJECT_EN
  task automatic test_fault_ready();
    logic [6:0] o, e;
    longint b, md, kt;
    b  = t + $urandom_range(1, 20);
    md = b + SL + FD + $urandom_range(0, 30);
    kt = md + WD + $urandom_range(0, 30);
    fault_sel = 2;
    bus.fault_mode = 2'd2;
    while (t < kt + RD + 20) begin
      o = obsv(); e = expv();
      total++;
      if (o !== e)
        $display("FAIL fault_ready t=%0d got=%b exp=%b", t, o, e);
      else passed++;
      if (t == b + 2) bus.fault_mode = 2'd0;
      drive(t >= b && t < b + 2,
            t >= md && t < md + 3,
            t >= kt && t < kt + 3);
    end
    fault_sel = 0;
  endtask
`endif

  initial begin
    fault_sel = 0;
    bus.arm = 1'b0;
    bus.detonator_triggered = 1'b0;
    bus.output_trigger = 1'b0;
`ifdef EMU_FAULT_INJECT_EN
    bus.fault_mode = 2'd0;
`endif
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    test_reset();
    test_phase();
    test_full_shot();
    test_rearm();
    test_out_of_order();
    test_reset_mid_shot();
    test_random();
`ifdef EMU_FAULT_INJECT_EN
    test_fault_ready();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
